// File: rtl/div_sched_if.sv
// Bundle of the divide scheduler's request, divider and writeback signals.
// master = surrounding pipeline (issue stage, divider, writeback arbiter).
// slave  = div_sched itself.
interface div_sched_if #(
  parameter int W      = 64,
  parameter int LG_ROB = 6,
  parameter int LG_PRF = 7
);
  // pipeline control
  logic              flush;
  // request side
  logic              req_valid;
  logic              req_ready;
  logic [W-1:0]      req_a;
  logic [W-1:0]      req_b;
  logic [LG_ROB-1:0] req_rob;
  logic [LG_PRF-1:0] req_prf;
  logic              req_signed;
  logic              req_rem;
  logic              req_w;
  // launch to divider
  logic              div_start;
  logic [W-1:0]      div_a;
  logic [W-1:0]      div_b;
  logic [LG_ROB-1:0] div_rob;
  logic [LG_PRF-1:0] div_prf;
  logic              div_signed;
  logic              div_rem;
  logic              div_w;
  // divider status / result
  logic              div_ready;
  logic              div_complete;
  logic [W-1:0]      div_y;
  logic [LG_ROB-1:0] div_rob_out;
  logic [LG_PRF-1:0] div_prf_out;
  // writeback port
  logic              wb_slot_used;
  logic              wb_valid;
  logic [W-1:0]      wb_data;
  logic [LG_ROB-1:0] wb_rob;
  logic [LG_PRF-1:0] wb_prf;
  logic              busy;

  modport master (
    output flush, req_valid, req_a, req_b, req_rob, req_prf, req_signed, req_rem, req_w,
    output div_ready, div_complete, div_y, div_rob_out, div_prf_out, wb_slot_used,
    input  req_ready, div_start, div_a, div_b, div_rob, div_prf, div_signed, div_rem, div_w,
    input  wb_valid, wb_data, wb_rob, wb_prf, busy
  );

  modport slave (
    input  flush, req_valid, req_a, req_b, req_rob, req_prf, req_signed, req_rem, req_w,
    input  div_ready, div_complete, div_y, div_rob_out, div_prf_out, wb_slot_used,
    output req_ready, div_start, div_a, div_b, div_rob, div_prf, div_signed, div_rem, div_w,
    output wb_valid, wb_data, wb_rob, wb_prf, busy
  );
endinterface

// File: rtl/div_sched.sv
// Issue scheduler for the shared iterative divider: 4-deep in-order queue, one divide in flight, one buffered result.
// Latency: push->launch 1 cycle when idle; div_complete->wb_valid 1 cycle minimum (zero-divisor bypass: pop->wb_valid 1 cycle).
// Backpressure: req_ready drops when the queue is full; issue stalls while a result waits on a busy writeback port.
// Optional macro DIV_SCHED_ZERO_BYPASS_EN: resolve divide-by-zero locally instead of sending it to the divider.
module div_sched #(
  parameter int W        = 64,
  parameter int LG_DEPTH = 2,
  parameter int LG_ROB   = 6,
  parameter int LG_PRF   = 7
) (
  input logic       clk,
  input logic       reset,
  div_sched_if.slave bus
);
  localparam int DEPTH = 1 << LG_DEPTH;

  typedef struct packed {
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic [LG_ROB-1:0] rob;
    logic [LG_PRF-1:0] prf;
    logic              sgn;
    logic              rem;
    logic              w;
  } entry_t;

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  entry_t            q_mem [DEPTH];
  entry_t            head;
  entry_t            new_entry;
  logic [LG_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [LG_DEPTH:0] rd_ptr_q, rd_ptr_d;
  state_t            state_q;
  logic              drop_q;
  logic              res_valid_q;
  logic [W-1:0]      res_data_q;
  logic [LG_ROB-1:0] res_rob_q;
  logic [LG_PRF-1:0] res_prf_q;

  logic              empty, full, push, pop, issue_ok, launch, bypass;
  logic              head_b_zero, wb_fire;
  logic [W-1:0]      byp_data;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[LG_DEPTH] != rd_ptr_q[LG_DEPTH]) &&
                 (wr_ptr_q[LG_DEPTH-1:0] == rd_ptr_q[LG_DEPTH-1:0]);
  assign head  = q_mem[rd_ptr_q[LG_DEPTH-1:0]];

  assign new_entry = '{a: bus.req_a, b: bus.req_b, rob: bus.req_rob, prf: bus.req_prf,
                       sgn: bus.req_signed, rem: bus.req_rem, w: bus.req_w};

  // A flushed cycle never accepts a request, even though req_ready may be high.
  assign push     = bus.req_valid && !full && !bus.flush;
  assign issue_ok = (state_q == IDLE) && !empty && !res_valid_q && !bus.flush;

`ifdef DIV_SCHED_ZERO_BYPASS_EN
  // Word ops only look at the low 32 bits of the divisor.
  assign head_b_zero = head.w ? (head.b[31:0] == 32'd0) : (head.b == '0);
  assign bypass      = issue_ok && head_b_zero;

  // RISC-V divide-by-zero: quotient is all ones, remainder is the dividend (word ops sign-extend bit 31).
  always_comb begin
    byp_data = '1;
    if (head.rem) begin
      byp_data = head.w ? {{(W-32){head.a[31]}}, head.a[31:0]} : head.a;
    end
  end
`else
  assign head_b_zero = 1'b0;
  assign bypass      = 1'b0;
  assign byp_data    = '0;
`endif

  assign launch  = issue_ok && !head_b_zero && bus.div_ready;
  assign pop     = launch || bypass;
  assign wb_fire = res_valid_q && !bus.wb_slot_used;

  // Next queue pointers; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (LG_DEPTH+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (LG_DEPTH+1)'(1);
    end
  end

  // Queue pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Queue storage; contents are don't-care until the write pointer covers them.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q[LG_DEPTH-1:0]] <= new_entry;
  end

  // Launch/wait FSM plus drop flag and the single-entry result buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rob_q   <= '0;
      res_prf_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) state_q <= WAIT;
        end
        WAIT: begin
          if (bus.div_complete) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
          end else if (bus.flush) begin
            // The in-flight divide cannot be aborted; remember to swallow its result.
            drop_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (bus.flush) begin
        res_valid_q <= 1'b0;
      end else if ((state_q == WAIT) && bus.div_complete && !drop_q) begin
        res_valid_q <= 1'b1;
        res_data_q  <= bus.div_y;
        res_rob_q   <= bus.div_rob_out;
        res_prf_q   <= bus.div_prf_out;
      end else if (bypass) begin
        res_valid_q <= 1'b1;
        res_data_q  <= byp_data;
        res_rob_q   <= head.rob;
        res_prf_q   <= head.prf;
      end else if (wb_fire) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = !full;

  // Divider operands are only driven during the launch pulse, zero otherwise.
  assign bus.div_start  = launch;
  assign bus.div_a      = launch ? head.a   : '0;
  assign bus.div_b      = launch ? head.b   : '0;
  assign bus.div_rob    = launch ? head.rob : '0;
  assign bus.div_prf    = launch ? head.prf : '0;
  assign bus.div_signed = launch && head.sgn;
  assign bus.div_rem    = launch && head.rem;
  assign bus.div_w      = launch && head.w;

  assign bus.wb_valid   = wb_fire;
  assign bus.wb_data    = res_data_q;
  assign bus.wb_rob     = res_rob_q;
  assign bus.wb_prf     = res_prf_q;

  assign bus.busy       = !empty || (state_q == WAIT) || res_valid_q;
endmodule
